// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream writer for the 16 x 8 instruction store with checksum-gated CPU release
module program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_instruction,
    output logic              cpu_hold,
    output logic [ADDR_W-1:0] load_addr,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERROR} state_t;

    state_t            state;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              xfer;
    logic [DATA_W-1:0] sum_next;

    assign in_ready       = (state == LOAD) || (state == CHECK);
    assign xfer           = in_valid && in_ready;
    assign sum_next       = sum + in_data;
    assign rd_instruction = mem[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            load_addr <= '0;
            sum       <= '0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    // A new load always re-enters CPU reset so the pc restarts at 0.
                    if (start) begin
                        state     <= LOAD;
                        load_addr <= '0;
                        sum       <= '0;
                        cpu_hold  <= 1'b1;
                        done      <= 1'b0;
                        err       <= 1'b0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        mem[load_addr] <= in_data;
                        sum            <= sum_next;
                        load_addr      <= load_addr + 1'b1;
                        if (load_addr == ADDR_W'(DEPTH - 1)) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    // Checksum byte is folded into the sum only; it never reaches memory.
                    if (xfer) begin
                        if (sum_next == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - table-driven and directed checks for program_loader
module tb_program_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] rd_addr = 4'h0;
    logic [7:0] rd_instruction;
    logic       cpu_hold;
    logic [3:0] load_addr;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    program_loader #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .rd_addr(rd_addr),
        .rd_instruction(rd_instruction), .cpu_hold(cpu_hold),
        .load_addr(load_addr), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] base;
        logic [7:0] step;
        logic [7:0] cks;
        logic       exp_done;
        logic       stall;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'h5A;
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: in_ready stayed 0 for byte %0h", b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic check_mem(input string name, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] exp;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            exp = base + step * 8'(i);
            #0.1;
            check(name, {24'h0, rd_instruction}, {24'h0, exp});
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h01, 8'h88, 1'b1, 1'b1};
        vecs[1] = '{8'hC0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h01, 8'h00, 8'hEF, 1'b0, 1'b0};
        vecs[3] = '{8'h10, 8'h10, 8'h80, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 8'hFF, 8'h87, 1'b0, 1'b0};

        // Asynchronous reset takes effect mid-cycle.
        #3 rst = 1'b1;
        #1;
        check("rst_hold",     {31'h0, cpu_hold}, 1);
        check("rst_done",     {31'h0, done},     0);
        check("rst_err",      {31'h0, err},      0);
        check("rst_ready",    {31'h0, in_ready}, 0);
        check("rst_load_addr",{28'h0, load_addr}, 0);
        check_mem("rst_mem", 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // start colliding with in_valid in IDLE: start wins, byte dropped.
        @(negedge clk);
        start = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        @(posedge clk);
        #1;
        start = 1'b0; in_valid = 1'b0;
        check("coll_ready",     {31'h0, in_ready}, 1);
        check("coll_load_addr", {28'h0, load_addr}, 0);
        rd_addr = 4'h0;
        #0.1;
        check("coll_mem0", {24'h0, rd_instruction}, 0);

        // start ignored mid-load.
        for (int i = 0; i < 7; i++) xfer(8'(i));
        check("ign_addr7", {28'h0, load_addr}, 7);
        pulse_start();
        check("ign_still7", {28'h0, load_addr}, 7);
        xfer(8'd7);
        check("ign_addr8", {28'h0, load_addr}, 8);
        for (int i = 8; i < 16; i++) xfer(8'(i));
        check("ign_ready_check", {31'h0, in_ready}, 1);
        xfer(8'h88);
        check("ign_done", {31'h0, done}, 1);

        for (int v = 0; v < 5; v++) begin
            pulse_start();
            check("vec_start_hold", {31'h0, cpu_hold}, 1);
            check("vec_start_done", {31'h0, done}, 0);
            check("vec_start_err",  {31'h0, err}, 0);
            check("vec_start_addr", {28'h0, load_addr}, 0);
            for (int i = 0; i < 16; i++) begin
                if (vecs[v].stall && (i % 3 == 2)) idle_cycle();
                xfer(vecs[v].base + vecs[v].step * 8'(i));
            end
            check("vec_pre_cks_hold", {31'h0, cpu_hold}, 1);
            xfer(vecs[v].cks);
            check("vec_done", {31'h0, done}, {31'h0, vecs[v].exp_done});
            check("vec_err",  {31'h0, err},  {31'h0, !vecs[v].exp_done});
            check("vec_hold", {31'h0, cpu_hold}, {31'h0, !vecs[v].exp_done});
            check("vec_addr", {28'h0, load_addr}, 0);
            check("vec_ready", {31'h0, in_ready}, 0);
            check_mem("vec_mem", vecs[v].base, vecs[v].step);
        end

        // Reset after 9 bytes discards the partial program.
        pulse_start();
        for (int i = 0; i < 9; i++) xfer(8'h33);
        check("mid_addr9", {28'h0, load_addr}, 9);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_addr",  {28'h0, load_addr}, 0);
        check("mid_rst_hold",  {31'h0, cpu_hold}, 1);
        check("mid_rst_ready", {31'h0, in_ready}, 0);
        check_mem("mid_rst_mem", 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        pulse_start();
        for (int i = 0; i < 16; i++) xfer(8'(i));
        xfer(8'h88);
        check("mid_reload_done", {31'h0, done}, 1);
        check("mid_reload_hold", {31'h0, cpu_hold}, 0);
        rd_addr = 4'd5;
        #0.1;
        check("mid_reload_rd5", {24'h0, rd_instruction}, 8'h05);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
